xcorr_sync_ctrl: RTL and testbench

- Sequencer that drives the xcorr_proc Hamming-distance datapath as a serial sync-word searcher.
- Shifts an incoming bitstream into an NDATA-bit window and compares every new window position against a reference pattern latched at start.
- Pipelines the distance and declares detection (normal or inverted polarity) against a programmable threshold, or timeout.
- Sits between the bit-recovery front end and the frame deframer.

---
 rtl/xcorr_sync_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_xcorr_sync_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_sync_ctrl.sv
// xcorr_sync_ctrl: serial sync-word searcher built around the xcorr_proc
// Hamming-distance datapath.
//
// Incoming bits shift into an NDATA-bit window (first-transmitted bit ends up
// at the MSB). Once the window is full, every accepted bit starts one
// comparison of the window against the reference latched at start. The
// comparison result is registered, then checked against the threshold for a
// normal match (dist <= thresh) or an inverted match (dist >= NDATA - thresh).
// The normal match takes priority. The search gives up after MAX_BITS bits.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin a search (honoured in IDLE only)
//   abort         cancel; beaten only by rst
//   ref_in        reference pattern, latched on accepted start
//   thresh        match threshold, latched on accepted start
//   bit_in        serial data bit
//   bit_valid     bit_in qualifier (used in FILL/SEARCH only)
//   busy          high in FILL and SEARCH
//   det           one-cycle pulse when the sync word is found
//   det_inv       qualifies det: 1 = inverted-polarity match
//   det_dist      distance of the matching window (held until the next det)
//   det_pos       1-based bit count of the completing bit (held)
//   timeout       one-cycle pulse when MAX_BITS bits pass with no match
//
// The datapath splits the window into NUM_LANES = NDATA/VEC_W lanes.
// NDATA must be a multiple of VEC_W.

module xcorr_lane #(
  parameter int VEC_W = 8,
  parameter int LW    = $clog2(VEC_W+1)
) (
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [LW-1:0]    pop
);
  always_comb begin
    pop = '0;
    for (int i = 0; i < VEC_W; i++) pop = pop + LW'(a[i] ^ b[i]);
  end
endmodule

// Combinational Hamming distance between dinA and dinB.
module xcorr_proc #(
  parameter int NDATA = 128,
  parameter int VEC_W = 8,
  parameter int DW    = $clog2(NDATA)+1
) (
  input  logic [NDATA-1:0] dinA,
  input  logic [NDATA-1:0] dinB,
  output logic [DW-1:0]    dout
);
  localparam int NUM_LANES = NDATA / VEC_W;
  localparam int LW        = $clog2(VEC_W+1);

  logic [NUM_LANES-1:0][LW-1:0] lane_pop;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      xcorr_lane #(.VEC_W(VEC_W), .LW(LW)) u_lane (
        .a   (dinA[g*VEC_W +: VEC_W]),
        .b   (dinB[g*VEC_W +: VEC_W]),
        .pop (lane_pop[g])
      );
    end
  endgenerate

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_LANES; i++) dout = dout + DW'(lane_pop[i]);
  end
endmodule

module xcorr_sync_ctrl #(
  parameter int NDATA    = 128,
  parameter int MAX_BITS = 4096,
  parameter int VEC_W    = 8,
  localparam int DW      = $clog2(NDATA)+1,
  localparam int CW      = $clog2(MAX_BITS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NDATA-1:0] ref_in,
  input  logic [DW-1:0]    thresh,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             det,
  output logic             det_inv,
  output logic [DW-1:0]    det_dist,
  output logic [CW-1:0]    det_pos,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, FILL, SEARCH} state_t;

  localparam logic [CW-1:0] MAXC = CW'(MAX_BITS);
  localparam logic [CW-1:0] NDC  = CW'(NDATA);

  state_t           state, nstate;
  logic [NDATA-1:0] win, ref_q;
  logic [DW-1:0]    thr_q;
  logic [CW-1:0]    cnt, cnt_inc;
  logic [DW-1:0]    dout;

  // vld_pipe[0]: window holds a comparison candidate (tag in iss_tag)
  // vld_pipe[1]: distance registered (s1_dist / s1_tag)
  logic [1:0]       vld_pipe;
  logic [CW-1:0]    iss_tag, s1_tag;
  logic [DW-1:0]    s1_dist;

  logic norm_m, inv_m;
  logic acc, hit, hit_inv, tout, start_ok;

  xcorr_proc #(.NDATA(NDATA), .VEC_W(VEC_W), .DW(DW)) u_proc (
    .dinA (win),
    .dinB (ref_q),
    .dout (dout)
  );

  assign cnt_inc = cnt + CW'(1);
  assign busy    = (state == FILL) || (state == SEARCH);

  // dist >= NDATA - thresh, rearranged to avoid underflow for large thresh.
  assign norm_m = vld_pipe[1] && (s1_dist <= thr_q);
  assign inv_m  = vld_pipe[1] &&
                  (({1'b0, s1_dist} + {1'b0, thr_q}) >= (DW+1)'(NDATA));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate   = state;
    acc      = 1'b0;
    hit      = 1'b0;
    hit_inv  = 1'b0;
    tout     = 1'b0;
    start_ok = 1'b0;
    if (abort) begin
      nstate = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            start_ok = 1'b1;
            nstate   = FILL;
          end
        end
        FILL, SEARCH: begin
          // A resolving comparison ends the search; the bit offered in the
          // same cycle is dropped along with everything still in flight.
          if (norm_m || inv_m) begin
            hit     = 1'b1;
            hit_inv = !norm_m;
            nstate  = IDLE;
          end else if (vld_pipe[1] && s1_tag == MAXC) begin
            tout   = 1'b1;
            nstate = IDLE;
          end else if (bit_valid && cnt != MAXC) begin
            acc = 1'b1;
            if (state == FILL && cnt_inc == NDC) nstate = SEARCH;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win      <= '0;
      ref_q    <= '0;
      thr_q    <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
      iss_tag  <= '0;
      s1_tag   <= '0;
      s1_dist  <= '0;
      det      <= 1'b0;
      det_inv  <= 1'b0;
      det_dist <= '0;
      det_pos  <= '0;
      timeout  <= 1'b0;
    end else begin
      det     <= hit;
      det_inv <= hit & hit_inv;
      timeout <= tout;
      if (hit) begin
        det_dist <= s1_dist;
        det_pos  <= s1_tag;
      end

      if (start_ok) begin
        ref_q <= ref_in;
        thr_q <= thresh;
        win   <= '0;
        cnt   <= '0;
      end else if (acc) begin
        win <= {win[NDATA-2:0], bit_in};
        cnt <= cnt_inc;
      end

      vld_pipe[0] <= acc && (cnt_inc >= NDC);
      iss_tag     <= cnt_inc;
      vld_pipe[1] <= vld_pipe[0];
      s1_dist     <= dout;
      s1_tag      <= iss_tag;
      if (abort || hit || tout) vld_pipe <= '0;
    end
  end
endmodule

// File: tb/tb_xcorr_sync_ctrl.sv
module tb_xcorr_sync_ctrl;
  localparam int NDATA = 16;
  localparam int MAXB  = 64;
  localparam int DW    = $clog2(NDATA)+1;
  localparam int CW    = $clog2(MAXB+1);

  logic clk = 1'b0;
  logic rst, start, abort, bit_in, bit_valid;
  logic [NDATA-1:0] ref_in;
  logic [DW-1:0] thresh;
  logic busy, det, det_inv, timeout;
  logic [DW-1:0] det_dist;
  logic [CW-1:0] det_pos;

  int total = 0;
  int bad   = 0;
  int prev_dist = 0;
  int prev_pos  = 0;

  always #5 clk = ~clk;

  xcorr_sync_ctrl #(.NDATA(NDATA), .MAX_BITS(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ref_in(ref_in),
    .thresh(thresh), .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy),
    .det(det), .det_inv(det_inv), .det_dist(det_dist), .det_pos(det_pos),
    .timeout(timeout)
  );

  typedef struct {
    logic [15:0] refv;
    int          th;
    int          npre;
    logic [7:0]  pre;
    logic [15:0] data;
    bit          glitch;   // pulse start (with a different ref) mid-SEARCH
    bit          edet;
    bit          einv;
    int          edist;
    int          epos;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] r, input int th);
    start = 1'b1; ref_in = r; thresh = DW'(th); bit_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_det"}, int'(det), 0);
    chk({nm, "_inv"}, int'(det_inv), 0);
    chk({nm, "_tout"}, int'(timeout), 0);
    chk({nm, "_dist"}, int'(det_dist), 0);
    chk({nm, "_pos"}, int'(det_pos), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] p;
    logic [15:0] d;
    p = v.pre;
    d = v.data;
    do_start(v.refv, v.th);
    for (int i = 0; i < v.npre; i++) begin
      bit_valid = 1'b1; bit_in = p[v.npre-1-i];
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1; bit_in = d[15-i];
      if (v.glitch && i == 12) begin start = 1'b1; ref_in = ~v.refv; thresh = '0; end
      tick();
      start = 1'b0;
    end
    bit_valid = 1'b0;
    tick();
    chk({nm, "_lat1_det"}, int'(det), 0);
    tick();
    chk({nm, "_det"}, int'(det), int'(v.edet));
    if (v.edet) begin
      chk({nm, "_inv"}, int'(det_inv), int'(v.einv));
      chk({nm, "_dist"}, int'(det_dist), v.edist);
      chk({nm, "_pos"}, int'(det_pos), v.epos);
      prev_dist = v.edist; prev_pos = v.epos;
    end
    tick();
    chk({nm, "_busy_after"}, int'(busy), v.edet ? 0 : 1);
    chk({nm, "_det_pulse"}, int'(det), 0);
    if (!v.edet) begin
      abort = 1'b1; tick(); abort = 1'b0;
      chk({nm, "_abort_idle"}, int'(busy), 0);
    end
  endtask

  // Random search against a reference model: the window is simply the last
  // 16 accepted bits as a number, distance is a popcount of the XOR.
  task automatic rand_trial(input int t);
    logic [15:0] r, w;
    logic s[80];
    int th, cnt, idx, endc, d, edist, epos;
    bit active, bv, b, einv, etout, done;
    r = 16'($urandom);
    th = $urandom_range(0, 3);
    for (int i = 0; i < 80; i++) s[i] = 1'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      logic [15:0] pat;
      int p0;
      pat = ($urandom_range(0, 1) == 1) ? ~r : r;
      pat = pat ^ (16'(1) << $urandom_range(0, 15)) ^ (16'(1) << $urandom_range(0, 15));
      p0 = $urandom_range(0, 60);
      for (int i = 0; i < 16; i++) s[p0+i] = pat[15-i];
    end
    do_start(r, th);
    cnt = 0; idx = 0; w = '0; endc = -1; active = 1; done = 0;
    edist = 0; epos = 0; einv = 0; etout = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      bv = ($urandom_range(0, 3) != 0);
      b = (idx < 80) ? s[idx] : 1'($urandom);
      bit_valid = bv; bit_in = b;
      if (active && bv && cnt < MAXB) begin
        idx++; cnt++;
        w = 16'((int'(w) * 2 + int'(b)) % 65536);
        if (cnt >= NDATA) begin
          d = $countones(w ^ r);
          if (d <= th || d >= NDATA - th) begin
            active = 0; endc = cyc + 2;
            edist = d; epos = cnt; einv = (d > th);
          end else if (cnt == MAXB) begin
            active = 0; endc = cyc + 2; etout = 1;
          end
        end
      end
      tick();
      if (cyc == endc) begin
        chk($sformatf("rnd%0d_det", t), int'(det), etout ? 0 : 1);
        chk($sformatf("rnd%0d_tout", t), int'(timeout), int'(etout));
        if (!etout) begin
          chk($sformatf("rnd%0d_inv", t), int'(det_inv), int'(einv));
          chk($sformatf("rnd%0d_dist", t), int'(det_dist), edist);
          chk($sformatf("rnd%0d_pos", t), int'(det_pos), epos);
          prev_dist = edist; prev_pos = epos;
        end
        chk($sformatf("rnd%0d_busy", t), int'(busy), 0);
        done = 1;
      end else begin
        chk($sformatf("rnd%0d_quiet_c%0d", t, cyc), int'(det | timeout), 0);
      end
    end
    bit_valid = 1'b0;
    if (!done) chk($sformatf("rnd%0d_budget", t), 0, 1);
    if (busy) begin abort = 1'b1; tick(); abort = 1'b0; end
  endtask

  initial begin
    bit nodet;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    ref_in = '0; thresh = '0;
    tbl[0] = '{16'hA5C3, 0, 8, 8'h00, 16'hA5C3, 0, 1, 0, 0, 24};
    tbl[1] = '{16'hA5C3, 2, 0, 8'h00, 16'hA5E2, 0, 1, 0, 2, 16};
    tbl[2] = '{16'hA5C3, 2, 0, 8'h00, 16'hA1E2, 0, 0, 0, 0, 0};
    tbl[3] = '{16'hA5C3, 1, 0, 8'h00, 16'h5A3C, 0, 1, 1, 16, 16};
    tbl[4] = '{16'hA5C3, 8, 0, 8'h00, 16'hA5C3, 0, 1, 0, 0, 16};
    tbl[5] = '{16'hA5C3, 8, 0, 8'h00, 16'hA53C, 0, 1, 0, 8, 16};
    tbl[6] = '{16'hA5C3, 0, 8, 8'h00, 16'hA5C3, 1, 1, 0, 0, 24};

    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // timeout: all-zero stream never matches A5C3 (distance 8)
    do_start(16'hA5C3, 0);
    nodet = 1;
    for (int i = 0; i < MAXB; i++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      tick();
      if (det || timeout) nodet = 0;
    end
    chk("tout_quiet", int'(nodet), 1);
    tick();
    chk("tout_lat1", int'(timeout), 0);
    chk("tout_lat1_busy", int'(busy), 1);
    tick();
    chk("tout_pulse", int'(timeout), 1);
    chk("tout_nodet", int'(det), 0);
    tick();
    chk("tout_one_cycle", int'(timeout), 0);
    chk("tout_busy", int'(busy), 0);
    bit_valid = 1'b0;

    // abort one cycle after the matching bit
    do_start(16'hA5C3, 2);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] d;
      d = 16'hA5E2;
      bit_valid = 1'b1; bit_in = d[15-i];
      tick();
    end
    bit_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_c1_det", int'(det), 0);
    tick();
    chk("abort_c2_det", int'(det), 0);
    tick();
    chk("abort_c3_det", int'(det), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_dist_held", int'(det_dist), prev_dist);
    chk("abort_pos_held", int'(det_pos), prev_pos);

    // bit_valid in IDLE is ignored, a fresh start still counts from 1
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      tick();
      chk("idle_bits_busy", int'(busy), 0);
    end
    bit_valid = 1'b0;
    run_vec(tbl[1], "after_idle_bits");

    // reset in the middle of FILL
    do_start(16'hA5C3, 0);
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    run_vec(tbl[0], "after_rst");

    for (int t = 0; t < 40; t++) rand_trial(t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
